// File: rtl/ex_result_stage_pkg.sv
// Shared core definitions for the EX result stage: ALU opcodes, CCR bit indices,
// EX/MEM entry layout, buffer occupancy encoding and the flag-derivation helper.
package ex_result_stage_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 3;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SETC = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_AND  = 3'b011,
    ALU_NOT  = 3'b100,
    ALU_RSV5 = 3'b101,
    ALU_RSV6 = 3'b110,
    ALU_NOP  = 3'b111
  } alu_op_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

  // Entry packing, LSB first: mem_wr, mem_rd, wb_en, rdst, then result on top.
  localparam int ENT_MEM_WR   = 0;
  localparam int ENT_MEM_RD   = 1;
  localparam int ENT_WB_EN    = 2;
  localparam int ENT_RDST_LSB = 3;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_FULL  = 2'b10
  } occ_e;

  function automatic logic [2:0] derive_flags(input logic [2:0] cur, input logic [2:0] op,
                                              input logic zero, input logic neg,
                                              input logic carry);
    logic [2:0] f;
    f = cur;
    case (op)
      ALU_ADD: begin
        f[FLAG_N] = neg;
        f[FLAG_Z] = zero;
        f[FLAG_C] = carry;
      end
      ALU_SETC: f[FLAG_C] = 1'b1;
      ALU_SUB, ALU_AND, ALU_NOT: begin
        f[FLAG_N] = neg;
        f[FLAG_Z] = zero;
      end
      default: f = cur;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ex_result_stage_ccr_unit.sv
// Condition-code register: derives Z/N/C from accepted ALU results.
// Optional interrupt shadow copy is built when EX_CCR_SHADOW_EN is defined.
module ccr_unit
  import ex_result_stage_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          upd,
  input  logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_carry,
  input  logic          int_save,
  input  logic          int_restore,
  output logic [2:0]    ccr
);

  logic [2:0] ccr_d, ccr_q;
  logic       res_zero;

  assign res_zero = (alu_result == {DW{1'b0}});
  assign ccr      = ccr_q;

`ifdef EX_CCR_SHADOW_EN
  logic [2:0] shadow_d, shadow_q;

  // Restore wins over a same-cycle flag update; save always captures the old value.
  always_comb begin
    ccr_d    = ccr_q;
    shadow_d = shadow_q;
    if (upd) begin
      ccr_d = derive_flags(ccr_q, alu_op, res_zero, alu_result[DW-1], alu_carry);
    end else begin
      ccr_d = ccr_q;
    end
    if (int_save) begin
      shadow_d = ccr_q;
    end else begin
      shadow_d = shadow_q;
    end
    if (int_restore) begin
      ccr_d = shadow_q;
    end else begin
      ccr_d = ccr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_q    <= 3'b000;
      shadow_q <= 3'b000;
    end else begin
      ccr_q    <= ccr_d;
      shadow_q <= shadow_d;
    end
  end
`else
  logic unused_shadow_ctl;
  assign unused_shadow_ctl = int_save | int_restore;

  always_comb begin
    ccr_d = ccr_q;
    if (upd) begin
      ccr_d = derive_flags(ccr_q, alu_op, res_zero, alu_result[DW-1], alu_carry);
    end else begin
      ccr_d = ccr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_q <= 3'b000;
    end else begin
      ccr_q <= ccr_d;
    end
  end
`endif

endmodule

// File: rtl/ex_result_stage.sv
// EX result stage: 2-entry EX/MEM skid buffer with valid/ready handshake and flush,
// plus the CCR unit. Build with EX_CCR_SHADOW_EN for the interrupt shadow CCR.
module ex_result_stage
  import ex_result_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_carry,
  input  logic [2:0]    alu_op,
  input  logic          upd_flags,
  input  logic [RW-1:0] rdst,
  input  logic          wb_en,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_rdst,
  output logic          out_wb_en,
  output logic          out_mem_rd,
  output logic          out_mem_wr,
  output logic [2:0]    ccr,
  input  logic          int_save,
  input  logic          int_restore
);

  localparam int EW = DW + RW + 3;

  occ_e          occ_d, occ_q;
  logic [EW-1:0] head_d, head_q, tail_d, tail_q, in_entry;
  logic          accept, pop;

  // Handshake status comes only from registered occupancy, never from out_ready.
  assign in_ready = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != OCC_EMPTY);
  assign accept   = in_valid & in_ready & ~flush;
  assign pop      = out_valid & out_ready & ~flush;
  assign in_entry = {alu_result, rdst, wb_en, mem_rd, mem_wr};

  assign out_result = head_q[EW-1 -: DW];
  assign out_rdst   = head_q[ENT_RDST_LSB +: RW];
  assign out_wb_en  = head_q[ENT_WB_EN];
  assign out_mem_rd = head_q[ENT_MEM_RD];
  assign out_mem_wr = head_q[ENT_MEM_WR];

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            head_d = in_entry;
            occ_d  = OCC_ONE;
          end else begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (accept && pop) begin
            head_d = in_entry;
          end else if (accept) begin
            tail_d = in_entry;
            occ_d  = OCC_FULL;
          end else if (pop) begin
            occ_d = OCC_EMPTY;
          end else begin
            occ_d = OCC_ONE;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            head_d = tail_q;
            occ_d  = OCC_ONE;
          end else begin
            occ_d = OCC_FULL;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= OCC_EMPTY;
      head_q <= {EW{1'b0}};
      tail_q <= {EW{1'b0}};
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  ccr_unit #(.DW(DW)) u_ccr (
    .clk         (clk),
    .rst         (rst),
    .upd         (accept & upd_flags),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .int_save    (int_save),
    .int_restore (int_restore),
    .ccr         (ccr)
  );

endmodule

// File: doc/ex_result_stage.md
# ex_result_stage

Execute-stage back end of the 16-bit core: consumes the ALU's result and carry, derives the Z/N/C condition flags, and owns the architectural condition-code register (CCR) that feeds the ALU's `flags_in`. Results plus their write-back and memory controls are held in a 2-entry EX/MEM skid buffer with a valid/ready handshake toward the memory stage, with pipeline flush support.

## Interface
Parameters:
- `DW`, 16, datapath width (ALU result width)
- `RW`, 3, destination register index width

Ports:
- Clock and reset: single clock `clk`; reset `rst` is synchronous, active-high.
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  synchronous active-high reset
- `in_valid`  in  1  EX holds a valid instruction this cycle
- `in_ready`  out  1  stage can accept (buffer not full)
- `alu_result`  in  DW  ALU result
- `alu_carry`  in  1  ALU carry-out (`flags_out[0]`)
- `alu_op`  in  3  ALU operation code of the instruction
- `upd_flags`  in  1  decode permits flag update for this instruction
- `rdst`  in  RW  destination register index
- `wb_en`, `mem_rd`, `mem_wr`  in  1 each  downstream controls
- `flush`  in  1  discard buffered and incoming instructions
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  memory stage accepts head entry
- `out_result`  out  DW, `out_rdst` out RW, `out_wb_en`/`out_mem_rd`/`out_mem_wr` out 1  head entry fields
- `ccr`  out  3  condition flags {N,Z,C}; bit0=C, bit1=Z, bit2=N; wired to ALU `flags_in`
- `int_save`, `int_restore`  in  1  CCR shadow controls (only with `EX_CCR_SHADOW_EN`)

## Operation
- Accept = `in_valid & in_ready & ~flush`. Pop = `out_valid & out_ready & ~flush`.
- Buffer: 2-entry FIFO of {result, rdst, wb_en, mem_rd, mem_wr}; occupancy states EMPTY, ONE, FULL.
  - EMPTY: accept -> ONE.
  - ONE: accept & ~pop -> FULL; pop & ~accept -> EMPTY; both -> ONE (head replaced by new entry).
  - FULL: pop -> ONE; accept impossible (`in_ready`=0).
  - `flush` -> EMPTY from any state; incoming instruction same cycle dropped.
- Flag derivation on accept when `upd_flags`=1 (Z = result==0, N = result[DW-1]):
  - op 000 (add): N, Z, C all updated, C = `alu_carry`.
  - op 001 (setc): C <= 1; N, Z unchanged.
  - op 010/011/100 (sub, and, not): N, Z updated; C unchanged.
  - op 101/110/111: no flag change.
  - `upd_flags`=0 or no accept: CCR unchanged.
- Flush does not roll back CCR; flags from already-accepted instructions persist.

## Timing
- Reset: occupancy EMPTY, `out_valid`=0, `in_ready`=1, `ccr`=3'b000, all `out_*` data fields 0, shadow CCR 0.
- `in_ready` = occupancy != FULL, registered-state derived; no combinational path from `out_ready` to `in_ready`.
- Latency: accepted entry appears on `out_*` with `out_valid`=1 on next cycle when buffer was empty; FIFO order preserved.
- `ccr` updates the cycle after accept; a back-to-back ALU instruction sees the new flags.
- Head fields stable while `out_valid`=1 and `out_ready`=0.
- `rst` mid-operation: all state returns to reset values on that edge, regardless of `flush`/handshakes.

## Configuration
- `EX_CCR_SHADOW_EN` defined: shadow CCR register present. `int_save` -> shadow <= current `ccr` (pre-update value). `int_restore` -> `ccr` <= shadow, overriding any same-cycle flag update. Both asserted same cycle -> swap (shadow <= old ccr, ccr <= old shadow).
- Undefined: no shadow register; `int_save`/`int_restore` ports present but ignored.

## Structure
- Shared core package: ALU opcode constants (ADD=000 … NOP=111), flag bit indices (C=0, Z=1, N=2), DW/RW defaults, EX/MEM entry field layout.
- Sub-module `ccr_unit`: flag derivation, CCR and shadow register; top holds FIFO and handshake.

## Test plan
- Reset then idle -> `ccr`=000, `out_valid`=0, `in_ready`=1.
- Accept add, result 0x0000, carry 1 -> next cycle `ccr`=3'b011, `out_result`=0x0000, `out_valid`=1.
- Three accepts with `out_ready`=0 -> after two, `in_ready`=0; third held; release `out_ready` -> entries drain in order 1,2,3.
- CCR=001, accept sub result 0x8000 -> `ccr`=3'b101 (C kept); then setc -> `ccr`=3'b101.
- FULL buffer, `flush` with `in_valid`=1 -> next cycle EMPTY, `out_valid`=0, `ccr` unchanged.
- With `EX_CCR_SHADOW_EN`: ccr=010, `int_save`; add sets ccr=101; `int_restore` -> `ccr`=010.
